fft_8_frame_sched: RTL

FFT_8_FRAME_SCHED -- requirements
Module: fft_8_frame_sched

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_frame_buf.sv | 47 ++++
 rtl/fft_8_frame_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT frame scheduler: default sample
// width and frame size, scheduler state encoding and the helper that locates
// point k inside a packed frame vector.
package fft_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_PTS  = 8;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  // Lowest bit of point k in a frame packed as [k*w +: w].
  function automatic int unsigned pt_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// N_PTS x (real, imag) frame register file.
// One write port with a per-point enable mask (a single point or a whole
// frame can be written in one cycle) and a full-frame parallel read.
//   clk      : clock
//   wr_mask  : per-point write enable
//   wr_real  : packed write data, real parts (point k at [k*DATA_W +: DATA_W])
//   wr_imag  : packed write data, imaginary parts
//   rd_real  : packed stored frame, real parts
//   rd_imag  : packed stored frame, imaginary parts
module fft_frame_buf #(
  parameter int unsigned DATA_W = fft_pkg::DATA_W,
  parameter int unsigned N_PTS  = fft_pkg::N_PTS
) (
  input  logic                    clk,
  input  logic [N_PTS-1:0]        wr_mask,
  input  logic [N_PTS*DATA_W-1:0] wr_real,
  input  logic [N_PTS*DATA_W-1:0] wr_imag,
  output logic [N_PTS*DATA_W-1:0] rd_real,
  output logic [N_PTS*DATA_W-1:0] rd_imag
);

  import fft_pkg::*;

  // Storage is data-only; contents are don't-care after reset.
  for (genvar k = 0; k < N_PTS; k++) begin : g_pt
    logic [DATA_W-1:0] re_q, re_d;
    logic [DATA_W-1:0] im_q, im_d;

    always_comb begin
      re_d = re_q;
      im_d = im_q;
      if (wr_mask[k]) begin
        re_d = wr_real[pt_lsb(k, DATA_W) +: DATA_W];
        im_d = wr_imag[pt_lsb(k, DATA_W) +: DATA_W];
      end
    end

    always_ff @(posedge clk) begin
      re_q <= re_d;
      im_q <= im_d;
    end

    assign rd_real[pt_lsb(k, DATA_W) +: DATA_W] = re_q;
    assign rd_imag[pt_lsb(k, DATA_W) +: DATA_W] = im_q;
  end

endmodule

// File: rtl/fft_8_frame_sched.sv
// Frame scheduler around an 8-point FFT core: collects 8 input samples,
// launches the core, waits (bounded) for its result and streams the result
// out point by point.
//   clk, rst (sync, active-low)
//   s_valid/s_ready/s_real/s_imag       : input sample stream
//   core_start, core_in_real/imag       : launch pulse and frame to the core
//   core_out_real/imag, core_done       : core result frame and valid level
//   m_valid/m_ready/m_real/m_imag       : output sample stream
//   m_index, m_last                     : point index, high on point 7
//   busy                                : not in FILL
//   frame_cnt                           : fully drained frames (wrapping)
//   timeout_err, clr_err                : sticky core timeout flag and clear
module fft_8_frame_sched #(
  parameter int unsigned DATA_W      = fft_pkg::DATA_W,
  parameter int unsigned N_PTS       = fft_pkg::N_PTS,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_real,
  input  logic [DATA_W-1:0]       s_imag,
  output logic                    core_start,
  output logic [N_PTS*DATA_W-1:0] core_in_real,
  output logic [N_PTS*DATA_W-1:0] core_in_imag,
  input  logic [N_PTS*DATA_W-1:0] core_out_real,
  input  logic [N_PTS*DATA_W-1:0] core_out_imag,
  input  logic                    core_done,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_real,
  output logic [DATA_W-1:0]       m_imag,
  output logic [2:0]              m_index,
  output logic                    m_last,
  output logic                    busy,
  output logic [15:0]             frame_cnt,
  output logic                    timeout_err,
  input  logic                    clr_err
);

  import fft_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_PTS);
  localparam int unsigned TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic               s_ready_q, s_ready_d;
  logic               core_start_q, core_start_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic               busy_q, busy_d;
  logic               in_we, out_we, to_expire;
  logic [N_PTS-1:0]   in_mask, out_mask;
  logic [N_PTS*DATA_W-1:0] out_real, out_imag;

  // Input frame: one point per accepted sample.
  assign in_mask = in_we ? (N_PTS'(1) << wr_idx_q) : '0;

  fft_frame_buf #(.DATA_W(DATA_W), .N_PTS(N_PTS)) u_in_buf (
    .clk     (clk),
    .wr_mask (in_mask),
    .wr_real ({N_PTS{s_real}}),
    .wr_imag ({N_PTS{s_imag}}),
    .rd_real (core_in_real),
    .rd_imag (core_in_imag)
  );

  // Output frame: whole core result captured in one cycle.
  assign out_mask = {N_PTS{out_we}};

  fft_frame_buf #(.DATA_W(DATA_W), .N_PTS(N_PTS)) u_out_buf (
    .clk     (clk),
    .wr_mask (out_mask),
    .wr_real (core_out_real),
    .wr_imag (core_out_imag),
    .rd_real (out_real),
    .rd_imag (out_imag)
  );

  // Expiry is the WAIT cycle whose increment would reach TIMEOUT_CYC-1.
  assign to_expire = (32'(to_cnt_q) + 32'd1) == (TIMEOUT_CYC - 32'd1);

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    to_cnt_d      = to_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    timeout_err_d = timeout_err_q & ~clr_err;
    in_we         = 1'b0;
    out_we        = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (s_valid) begin
          in_we = 1'b1;
          if (wr_idx_q == IDX_W'(N_PTS - 1)) begin
            wr_idx_d = '0;
            state_d  = ST_LAUNCH;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      ST_LAUNCH: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // core_done takes priority over a coincident expiry.
        if (core_done) begin
          out_we   = 1'b1;
          rd_idx_d = '0;
          state_d  = ST_DRAIN;
        end else if (to_expire) begin
          timeout_err_d = 1'b1;
          wr_idx_d      = '0;
          state_d       = ST_FILL;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          if (rd_idx_q == IDX_W'(N_PTS - 1)) begin
            rd_idx_d    = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_FILL;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_FILL;
    endcase

    s_ready_d    = (state_d == ST_FILL);
    core_start_d = (state_d == ST_LAUNCH);
    m_valid_d    = (state_d == ST_DRAIN);
    busy_d       = (state_d != ST_FILL);
    m_last_d     = (state_d == ST_DRAIN) && (rd_idx_d == IDX_W'(N_PTS - 1));
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_FILL;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      to_cnt_q      <= '0;
      frame_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      s_ready_q     <= 1'b1;
      core_start_q  <= 1'b0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      to_cnt_q      <= to_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_err_q <= timeout_err_d;
      s_ready_q     <= s_ready_d;
      core_start_q  <= core_start_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      busy_q        <= busy_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign core_start  = core_start_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout_err = timeout_err_q;
  assign m_index     = 3'(rd_idx_q);
  assign m_real      = out_real[pt_lsb(32'(rd_idx_q), DATA_W) +: DATA_W];
  assign m_imag      = out_imag[pt_lsb(32'(rd_idx_q), DATA_W) +: DATA_W];

endmodule
